// File: rtl/seq_bit_serializer_if.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer_if
//
// Purpose:
//   Groups the word handshake and the serial-stream outputs of
//   seq_bit_serializer into one bundle. Clock and reset are kept outside the
//   interface as plain ports on the design.
//
// Signals:
//   din        [WIDTH-1:0]  parallel word to serialize
//   din_valid               din holds a word
//   din_ready               serializer can accept a word this cycle
//   x                       serial bit to the downstream detector
//   x_valid                 x carries a data bit this cycle
//   done                    pulse while the last bit of a word is on x
//   busy                    serializer is not idle
//
// Modports:
//   master : the word producer (drives din/din_valid, observes the rest)
//   slave  : the serializer itself
// -----------------------------------------------------------------------------
interface seq_bit_serializer_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x;
  logic             x_valid;
  logic             done;
  logic             busy;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  x,
    input  x_valid,
    input  done,
    input  busy
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output x,
    output x_valid,
    output done,
    output busy
  );

endinterface : seq_bit_serializer_if

// File: rtl/seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer
//
// Purpose:
//   Parallel-to-serial front end for the serial bit-stream sequence detectors.
//   Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit
//   per clock on x. While no word is in flight x is held at 0 so the detector
//   downstream falls back to its idle state.
//
//   A word accepted at edge k is on x during cycles k+1 .. k+WIDTH, with
//   x_valid high throughout and done high in the last of those cycles.
//
// Parameters:
//   WIDTH      word width in bits (WIDTH >= 2)
//   MSB_FIRST  1: din[WIDTH-1] leaves first, 0: din[0] leaves first
//
// Ports:
//   clk  rising-edge clock for every flop
//   rst  synchronous, active-high reset
//   bus  seq_bit_serializer_if.slave (din, din_valid, din_ready, x, x_valid,
//        done, busy)
//
// Build option:
//   SER_GAP_EN  when defined, every word is followed by exactly one GAP cycle
//               with x=0 / x_valid=0, so runs of 1s never span two words.
//               din_ready is then low for the whole SHIFT phase and high in
//               GAP and IDLE. When undefined, words can be back-to-back with
//               no idle cycle between them.
// -----------------------------------------------------------------------------
module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_bit_serializer_if.slave   bus
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int                 CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef SER_GAP_EN
  localparam logic [1:0] ST_GAP   = 2'd2;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_shift;    // bits of the current word not yet on x
  logic [CNT_W-1:0] r_cnt;      // index of the bit currently on x
  logic             r_x;
  logic             r_x_valid;
  logic             r_done;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic             w_last;
  logic             w_din_ready;
  logic             w_xfer;
  logic             w_first_bit;
  logic [WIDTH-1:0] w_load_shift;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_adv_shift;
  logic [CNT_W-1:0] w_cnt_inc;

  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_x_nxt;
  logic             w_x_valid_nxt;
  logic             w_done_nxt;

  assign w_last    = (r_cnt == LAST_CNT);
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // The first bit goes straight from din to the x register at the load edge;
  // the shift register keeps only the bits still to come, aligned so the next
  // one always sits at the output end.
  assign w_first_bit  = MSB_FIRST ? bus.din[WIDTH-1] : bus.din[0];
  assign w_load_shift = MSB_FIRST ? (bus.din << 1)   : (bus.din >> 1);
  assign w_next_bit   = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
  assign w_adv_shift  = MSB_FIRST ? (r_shift << 1)   : (r_shift >> 1);

  // NOTE: every signal written in an always_comb block gets a default at the
  // top, so no path through the case statements can infer a latch.
  always_comb begin
    w_din_ready = 1'b0;
    case (r_state)
      ST_IDLE:  w_din_ready = 1'b1;
`ifdef SER_GAP_EN
      ST_SHIFT: w_din_ready = 1'b0;
      ST_GAP:   w_din_ready = 1'b1;
`else
      // Ready on the last-bit cycle so the next word follows with no bubble.
      ST_SHIFT: w_din_ready = w_last;
`endif
      default:  w_din_ready = 1'b0;
    endcase
  end

  assign w_xfer = bus.din_valid && w_din_ready;

  // Next-state and next-output logic. x/x_valid/done default to the idle
  // values; only a load or an in-word advance drives them otherwise.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_cnt_nxt     = r_cnt;
    w_x_nxt       = 1'b0;
    w_x_valid_nxt = 1'b0;
    w_done_nxt    = 1'b0;

    if (w_xfer) begin
      // A transfer can only happen in a state where din_ready is high, so it
      // always starts a fresh word regardless of where it came from.
      w_state_nxt   = ST_SHIFT;
      w_shift_nxt   = w_load_shift;
      w_cnt_nxt     = '0;
      w_x_nxt       = w_first_bit;
      w_x_valid_nxt = 1'b1;
      w_done_nxt    = (LAST_CNT == '0);
    end else begin
      case (r_state)
        ST_SHIFT: begin
          if (!w_last) begin
            w_shift_nxt   = w_adv_shift;
            w_cnt_nxt     = w_cnt_inc;
            w_x_nxt       = w_next_bit;
            w_x_valid_nxt = 1'b1;
            // done rides along with the bit whose index is WIDTH-1.
            w_done_nxt    = (w_cnt_inc == LAST_CNT);
          end else begin
`ifdef SER_GAP_EN
            w_state_nxt = ST_GAP;
`else
            w_state_nxt = ST_IDLE;
`endif
          end
        end
`ifdef SER_GAP_EN
        ST_GAP:   w_state_nxt = ST_IDLE;
`endif
        ST_IDLE:  w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift register is reset along with the control state so the
      // block comes up with a fully known datapath; it is only a few flops.
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_x       <= 1'b0;
      r_x_valid <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_cnt     <= w_cnt_nxt;
      r_x       <= w_x_nxt;
      r_x_valid <= w_x_valid_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.din_ready = w_din_ready;
  assign bus.x         = r_x;
  assign bus.x_valid   = r_x_valid;
  assign bus.done      = r_done;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule : seq_bit_serializer

// File: tb/tb_seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_seq_bit_serializer
//
// Drives one stimulus stream into two serializers (MSB-first and LSB-first).
// A queue-based model turns every accepted word into the list of per-cycle
// outputs it must produce; a compare process checks both DUTs against that
// list on every falling edge. Directed tests add literal expectations for the
// exact bit streams, done positions, reset behaviour and backpressure.
// Builds with or without SER_GAP_EN.
// -----------------------------------------------------------------------------
module tb_seq_bit_serializer;

  localparam int WIDTH = 8;
`ifdef SER_GAP_EN
  localparam bit GAP      = 1'b1;
  localparam int ACC_EDGE = 9;   // edge at which a held second word is taken
`else
  localparam bit GAP      = 1'b0;
  localparam int ACC_EDGE = 8;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] din = '0;
  logic             din_valid = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seq_bit_serializer_if #(.WIDTH(WIDTH)) bus_m ();
  seq_bit_serializer_if #(.WIDTH(WIDTH)) bus_l ();

  assign bus_m.din       = din;
  assign bus_m.din_valid = din_valid;
  assign bus_l.din       = din;
  assign bus_l.din_valid = din_valid;

  seq_bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  seq_bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                  name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Model: one entry per future output cycle (x, x_valid, done, busy).
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic x;
    logic v;
    logic d;
    logic b;
  } exp_t;

  localparam exp_t IDLE_E = '0;

  exp_t q_m[$];
  exp_t q_l[$];
  exp_t cur_m = '0;
  exp_t cur_l = '0;
  bit   model_on = 1'b0;

  always @(posedge clk) begin : model
    bit rdy;
    rdy = (q_m.size() == 0);
    if (rst) begin
      q_m.delete();
      q_l.delete();
      cur_m    = IDLE_E;
      cur_l    = IDLE_E;
      model_on = 1'b1;
    end else begin
      if (din_valid && rdy) begin
        for (int i = 0; i < WIDTH; i++) begin
          q_m.push_back(exp_t'{x: din[WIDTH-1-i], v: 1'b1, d: (i == WIDTH-1), b: 1'b1});
          q_l.push_back(exp_t'{x: din[i],         v: 1'b1, d: (i == WIDTH-1), b: 1'b1});
        end
        if (GAP) begin
          q_m.push_back(exp_t'{x: 1'b0, v: 1'b0, d: 1'b0, b: 1'b1});
          q_l.push_back(exp_t'{x: 1'b0, v: 1'b0, d: 1'b0, b: 1'b1});
        end
      end
      cur_m = (q_m.size() != 0) ? q_m.pop_front() : IDLE_E;
      cur_l = (q_l.size() != 0) ? q_l.pop_front() : IDLE_E;
    end
  end

  // Ready is high exactly when nothing beyond the current cycle is queued.
  always @(negedge clk) begin
    if (model_on) begin
      check("msb.x",         bus_m.x,         cur_m.x);
      check("msb.x_valid",   bus_m.x_valid,   cur_m.v);
      check("msb.done",      bus_m.done,      cur_m.d);
      check("msb.busy",      bus_m.busy,      cur_m.b);
      check("msb.din_ready", bus_m.din_ready, (q_m.size() == 0));
      check("lsb.x",         bus_l.x,         cur_l.x);
      check("lsb.x_valid",   bus_l.x_valid,   cur_l.v);
      check("lsb.done",      bus_l.done,      cur_l.d);
      check("lsb.busy",      bus_l.busy,      cur_l.b);
      check("lsb.din_ready", bus_l.din_ready, (q_l.size() == 0));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus helpers
  // ---------------------------------------------------------------------------
  // Send one word and record cycles 1..9 after the accepting edge.
  task automatic send_capture(input logic [WIDTH-1:0] w,
                              output logic [8:0] xm, output logic [8:0] xl,
                              output logic [8:0] vv, output logic [8:0] dd);
    xm = '0; xl = '0; vv = '0; dd = '0;
    @(posedge clk); #1;
    din = w; din_valid = 1'b1;
    @(posedge clk); #1;          // accepting edge 0
    din_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      xm = {xm[7:0], bus_m.x};
      xl = {xl[7:0], bus_l.x};
      vv = {vv[7:0], bus_m.x_valid};
      dd = {dd[7:0], bus_m.done};
    end
  endtask

  logic [8:0]  xm9, xl9, v9, d9;
  logic [17:0] xm18, xl18, v18, d18;
  logic [7:0]  v8, d8;
  logic [15:0] dm16, dl16;
  int          nbits;

  initial begin
    // ---- 1. reset then idle ----
    rst = 1'b1; din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("idle.x",         bus_m.x,         1'b0);
      check("idle.x_valid",   bus_m.x_valid,   1'b0);
      check("idle.done",      bus_m.done,      1'b0);
      check("idle.din_ready", bus_m.din_ready, 1'b1);
      check("idle.busy",      bus_m.busy,      1'b0);
    end

    // ---- 2/3. single words, both bit orders ----
    send_capture(8'hE1, xm9, xl9, v9, d9);
    check("E1.msb_stream",  xm9, {8'hE1, 1'b0});
    check("E1.lsb_stream",  xl9, {8'h87, 1'b0});
    check("E1.valid_cycles", v9, 9'b1111_1111_0);
    check("E1.done_cycle",   d9, 9'b0000_0001_0);

    send_capture(8'hA5, xm9, xl9, v9, d9);
    check("A5.lsb_stream",  xl9, {8'hA5, 1'b0});
    check("A5.msb_stream",  xm9, {8'hA5, 1'b0});
    check("A5.done_cycle",   d9, 9'b0000_0001_0);

    // ---- 4. back-to-back FF then 0F with din_valid held ----
    xm18 = '0; xl18 = '0; v18 = '0; d18 = '0;
    @(posedge clk); #1;
    din = 8'hFF; din_valid = 1'b1;
    @(posedge clk); #1;          // edge 0
    din = 8'h0F;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      xm18 = {xm18[16:0], bus_m.x};
      xl18 = {xl18[16:0], bus_l.x};
      v18  = {v18[16:0],  bus_m.x_valid};
      d18  = {d18[16:0],  bus_m.done};
      @(posedge clk); #1;
      if (c == ACC_EDGE) din_valid = 1'b0;
    end
`ifdef SER_GAP_EN
    check("b2b.msb_stream", xm18, 18'b11111111_0_00001111_0);
    check("b2b.lsb_stream", xl18, 18'b11111111_0_11110000_0);
    check("b2b.valid",      v18,  18'b11111111_0_11111111_0);
    check("b2b.done",       d18,  18'b00000001_0_00000001_0);
`else
    check("b2b.msb_stream", xm18, 18'b11111111_00001111_00);
    check("b2b.lsb_stream", xl18, 18'b11111111_11110000_00);
    check("b2b.valid",      v18,  18'b11111111_11111111_00);
    check("b2b.done",       d18,  18'b00000001_00000001_00);
`endif

    // ---- 5. reset mid-word ----
    v8 = '0; d8 = '0;
    @(posedge clk); #1;
    din = 8'hFF; din_valid = 1'b1;
    @(posedge clk); #1;          // edge 0
    din_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      v8 = {v8[6:0], bus_m.x_valid};
      d8 = {d8[6:0], bus_m.done};
      if (c == 5) begin
        check("rst_mid.x",         bus_m.x,         1'b0);
        check("rst_mid.x_valid",   bus_m.x_valid,   1'b0);
        check("rst_mid.din_ready", bus_m.din_ready, 1'b1);
        check("rst_mid.busy",      bus_m.busy,      1'b0);
      end
      @(posedge clk); #1;
      if (c == 3) rst = 1'b1;    // sampled at edge 4
      if (c == 4) rst = 1'b0;
    end
    check("rst_mid.valid_cycles", v8, 8'b1111_0000);
    check("rst_mid.no_done",      d8, 8'h00);

    // ---- 6. backpressure: din toggles while not ready ----
    dm16 = '0; dl16 = '0; nbits = 0;
    @(posedge clk); #1;
    din = 8'h3C; din_valid = 1'b1;
    @(posedge clk); #1;          // edge 0
    for (int c = 1; c <= ACC_EDGE + 10; c++) begin
      @(negedge clk);
      if (bus_m.x_valid) begin
        dm16 = {dm16[14:0], bus_m.x};
        nbits++;
      end
      if (bus_l.x_valid) dl16 = {dl16[14:0], bus_l.x};
      @(posedge clk); #1;
      if (c < ACC_EDGE - 1)       din = c[0] ? 8'hFF : 8'h00;
      else if (c == ACC_EDGE - 1) din = 8'h5A;
      else if (c == ACC_EDGE)     din_valid = 1'b0;
    end
    check("bp.msb_words", dm16,  16'h3C5A);
    check("bp.lsb_words", dl16,  16'h3C5A);
    check("bp.bit_count", nbits, 16);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_seq_bit_serializer

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
Parallel-to-serial front end for the serial bit-stream sequence detectors. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on x. x connects directly to a detector's x input, which samples every clock. When no word is in flight, x is held at 0 so the downstream detector returns to its idle state.

Parameters:
WIDTH, 8, word width in bits; legal range WIDTH >= 2.
MSB_FIRST, 1, 1 = din[WIDTH-1] is shifted out first; 0 = din[0] is shifted out first.

Ports:
clk  input  1  single clock, all flops rising-edge.
rst  input  1  synchronous active-high reset.
din  input  WIDTH  parallel word to serialize.
din_valid  input  1  din holds a word.
din_ready  output  1  block can accept a word this cycle; decoded from state and bit counter.
x  output  1  serial bit to the detector; registered.
x_valid  output  1  x carries a data bit this cycle; registered.
done  output  1  one-cycle pulse during the cycle the last bit of a word is on x; registered.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, shift register=0, bit counter=0, x=0, x_valid=0, done=0. Consequently din_ready=1 and busy=0.
- Transfer: a word is accepted at a rising edge where din_valid && din_ready. din is ignored at every other edge, including changes while din_ready=0.
- FSM states: IDLE, SHIFT, and GAP (GAP exists only with SER_GAP_EN).
- IDLE:
  - din_ready=1.
  - On a transfer: load the shift register, set counter=0, go to SHIFT.
  - Outputs: x=0, x_valid=0.
- Latency: the word accepted at edge k appears on x during cycles k+1 through k+WIDTH, one bit per cycle, with x_valid=1 throughout.
- SHIFT:
  - Each edge shifts the next bit onto x and increments the counter, which counts 0..WIDTH-1.
  - done=1 in the cycle where the counter equals WIDTH-1.
- End of word (counter = WIDTH-1):
  - din_ready=1 in this cycle, giving back-to-back capability.
  - If a transfer occurs, load the new word and reset the counter to 0. The new word's first bit follows with no idle cycle, giving sustained throughput of one word per WIDTH cycles.
  - If no transfer occurs, go to IDLE. x=0 and x_valid=0 on the next cycle.
- Counter width: clog2(WIDTH). The counter never exceeds WIDTH-1; it wraps to 0 only on a load.
- Reset mid-word: asserting rst at any edge discards the word in flight. The next cycle shows reset values, and no done pulse is generated for the discarded word.
- Simultaneous rst and transfer: rst wins; the word is dropped.
- busy is 1 in SHIFT and GAP, 0 in IDLE.

Optional Feature:
Macro: SER_GAP_EN.
- Defined:
  - After the last bit of each word the FSM enters GAP for exactly one cycle, with x=0 and x_valid=0. This guarantees a 0 separator, so 1-runs cannot span word boundaries.
  - din_ready=0 during SHIFT, including the last-bit cycle. din_ready=1 in GAP and IDLE.
  - A transfer in GAP goes to SHIFT; otherwise GAP goes to IDLE.
  - Sustained throughput is one word per WIDTH+1 cycles.
- Not defined: the GAP state and its logic are absent, and back-to-back words are contiguous as described above.

Test Plan:
1. Reset then idle: hold rst 2 cycles, release, din_valid=0 -> x=0, x_valid=0, done=0, din_ready=1, busy=0 on every cycle.
2. WIDTH=8, MSB_FIRST=1, din=8'hE1 accepted at edge 0 -> x=1,1,1,0,0,0,0,1 in cycles 1-8; x_valid=1 in cycles 1-8 only; done=1 in cycle 8 only; cycle 9 shows x=0, x_valid=0.
3. MSB_FIRST=0, din=8'hA5 -> x=1,0,1,0,0,1,0,1; done in cycle 8.
4. Back-to-back, din_valid held high, words 8'hFF then 8'h0F:
   - Without SER_GAP_EN -> 16 contiguous x_valid cycles, x = eight 1s, four 0s, four 1s; done in cycles 8 and 16.
   - With SER_GAP_EN -> cycle 9 is x=0, x_valid=0; the second word occupies cycles 10-17.
5. Reset mid-word: accept 8'hFF, assert rst at edge 4 -> cycle 5 shows x=0, x_valid=0, din_ready=1, busy=0; done never pulses.
6. Backpressure: during SHIFT with counter < WIDTH-1, toggle din between 8'h00 and 8'hFF while din_valid=1 -> x stream unchanged; only the value present at the last-bit edge is loaded.
